csa_mul_seq: RTL and testbench
==============================

CSA_MUL_SEQ -- requirements
Module: csa_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter STEPS_AT_ONCE, default 1: shift-add steps per clock; WIDTH SHALL be a multiple of it.
REQ-003 SHALL have parameter CARRY_CHAIN, default 4: carry-save chunk size; 2*WIDTH SHALL be a multiple of it.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 SHALL have port rs1, input, WIDTH bits: multiplier.
REQ-009 SHALL have port rs2, input, WIDTH bits: multiplicand.
REQ-010 SHALL have port rs1_signed, input, 1 bit: treat rs1 as two's complement.
REQ-011 SHALL have port rs2_signed, input, 1 bit: treat rs2 as two's complement.
REQ-012 SHALL have port abort, input, 1 bit: synchronous cancel of an operation in flight.
REQ-013 SHALL have port out_valid, output, 1 bit: product is available.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-015 SHALL have port product, output, 2*WIDTH bits: full product.

Function
REQ-016 SHALL implement states IDLE, RUN, RESOLVE and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; operands SHALL be accepted when in_valid & in_ready.
REQ-018 On accept, SHALL register the operands extended to 2*WIDTH bits: sign-extended when the matching *_signed bit is 1, otherwise zero-extended.
REQ-019 On accept, SHALL clear accumulators rd and rdx to 0 and go to RUN.
REQ-020 On accept, SHALL load the step counter with ITER/STEPS_AT_ONCE, where ITER = WIDTH if both *_signed are 0, else 2*WIDTH.
REQ-021 Each RUN cycle SHALL perform STEPS_AT_ONCE chained steps.
REQ-022 Each step SHALL compute t = rs1[0] ? rs2 : 0.
REQ-023 Each step SHALL, per CARRY_CHAIN chunk, form the (CARRY_CHAIN+1)-bit sum rd + rdx + t; the low bits go to rd and the chunk carry to the chunk-top bit of rdt.
REQ-024 Each step SHALL then set rdx = rdt << 1, rs1 = rs1 >> 1 (logical) and rs2 = rs2 << 1, all truncated to 2*WIDTH bits.
REQ-025 SHALL decrement the counter once per RUN cycle and enter RESOLVE after the cycle in which it reaches 1.
REQ-026 RESOLVE SHALL last one cycle, register product = (rd + rdx) mod 2^(2*WIDTH), and enter DONE.
REQ-027 DONE SHALL hold out_valid = 1 with product stable until out_ready = 1, then go to IDLE on that edge.
REQ-028 Latency: out_valid SHALL rise exactly ITER/STEPS_AT_ONCE + 1 cycles after the accept edge.
REQ-029 abort = 1 in RUN or RESOLVE SHALL return to IDLE on the next edge, with no out_valid pulse and product unchanged.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 in_valid SHALL be ignored outside IDLE; there SHALL be no operand queueing.
REQ-032 The product SHALL equal the exact mathematical product of the interpreted operands for every operand and signedness combination.

Reset
REQ-033 While reset = 1, state SHALL be IDLE, in_ready = 1, out_valid = 0, and product, rd, rdx and the counter SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-operation SHALL discard that operation; the first edge after deassert SHALL accept new operands.

Verification
REQ-035 With WIDTH=32, STEPS=1, unsigned 3*5: out_valid rises 33 cycles after accept; product = 0x0000000000000F.
REQ-036 With WIDTH=32, unsigned 0xFFFFFFFF*0xFFFFFFFF: product = 0xFFFFFFFE00000001.
REQ-037 With WIDTH=32, signed 0xFFFFFFFF*0x00000002: product = 0xFFFFFFFFFFFFFFFE after 65 cycles; with rs1 signed and rs2 unsigned, -1*0xFFFFFFFF = 0xFFFFFFFF00000001.
REQ-038 out_ready held 0 for 10 cycles in DONE: out_valid and product stay stable, in_ready stays 0, and in_valid is ignored.
REQ-039 abort at cycle 5 of RUN: IDLE next cycle, no out_valid; a following 7*6 returns 42.
REQ-040 reset pulsed mid-RUN: all outputs return to their REQ-033 values immediately; with WIDTH=8, STEPS=2, a following unsigned 0xFF*0xFF returns 0xFE01 after 5 cycles.

Source files
------------

// File: rtl/csa_mul_seq.sv
// Sequential shift-add multiplier whose accumulator is kept in carry-save
// form (rd + rdx), so no carry ripples further than one chunk per step.
module csa_mul_seq #(
  parameter int WIDTH         = 32,
  parameter int STEPS_AT_ONCE = 1,
  parameter int CARRY_CHAIN   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rs1,
  input  logic [WIDTH-1:0]   rs2,
  input  logic               rs1_signed,
  input  logic               rs2_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int W2     = 2 * WIDTH;
  localparam int CW     = $clog2(W2 + 1);
  localparam int NCHUNK = W2 / CARRY_CHAIN;
  localparam logic [CW-1:0] CNT_UNSIGNED = CW'(WIDTH / STEPS_AT_ONCE);
  localparam logic [CW-1:0] CNT_SIGNED   = CW'(W2 / STEPS_AT_ONCE);

  typedef enum logic [1:0] {IDLE, RUN, RESOLVE, DONE} state_t;

  state_t          state;
  logic [W2-1:0]   mplier, mcand, rd, rdx;
  logic [CW-1:0]   cnt;

  logic [W2-1:0]   nxt_mplier, nxt_mcand, nxt_rd, nxt_rdx;
  logic [W2-1:0]   step_t, step_rdt;
  logic [CARRY_CHAIN:0] step_sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Each rdx chunk holds at most its bottom bit (a shifted-in chunk carry),
  // so rd + rdx + t per chunk always fits in CARRY_CHAIN+1 bits.
  always_comb begin
    nxt_mplier = mplier;
    nxt_mcand  = mcand;
    nxt_rd     = rd;
    nxt_rdx    = rdx;
    step_t     = '0;
    step_rdt   = '0;
    step_sum   = '0;
    for (int s = 0; s < STEPS_AT_ONCE; s++) begin
      step_t   = nxt_mplier[0] ? nxt_mcand : '0;
      step_rdt = '0;
      for (int c = 0; c < NCHUNK; c++) begin
        step_sum = {1'b0, nxt_rd[c*CARRY_CHAIN +: CARRY_CHAIN]}
                 + {1'b0, nxt_rdx[c*CARRY_CHAIN +: CARRY_CHAIN]}
                 + {1'b0, step_t[c*CARRY_CHAIN +: CARRY_CHAIN]};
        nxt_rd[c*CARRY_CHAIN +: CARRY_CHAIN] = step_sum[CARRY_CHAIN-1:0];
        step_rdt[c*CARRY_CHAIN + CARRY_CHAIN - 1] = step_sum[CARRY_CHAIN];
      end
      nxt_rdx    = step_rdt << 1;
      nxt_mplier = nxt_mplier >> 1;
      nxt_mcand  = nxt_mcand << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mplier  <= '0;
      mcand   <= '0;
      rd      <= '0;
      rdx     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mplier <= {{WIDTH{rs1_signed & rs1[WIDTH-1]}}, rs1};
            mcand  <= {{WIDTH{rs2_signed & rs2[WIDTH-1]}}, rs2};
            rd     <= '0;
            rdx    <= '0;
            cnt    <= (rs1_signed | rs2_signed) ? CNT_SIGNED : CNT_UNSIGNED;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            mplier <= nxt_mplier;
            mcand  <= nxt_mcand;
            rd     <= nxt_rd;
            rdx    <= nxt_rdx;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            product <= rd + rdx;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mul_seq.sv
// Directed bench for csa_mul_seq: a 32-bit/1-step instance and an
// 8-bit/2-step instance sharing clock and reset.
module tb_csa_mul_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_rs1_signed, a_rs2_signed;
  logic        a_abort, a_out_valid, a_out_ready;
  logic [31:0] a_rs1, a_rs2;
  logic [63:0] a_product;

  logic        b_in_valid, b_in_ready, b_rs1_signed, b_rs2_signed;
  logic        b_abort, b_out_valid, b_out_ready;
  logic [7:0]  b_rs1, b_rs2;
  logic [15:0] b_product;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_p32;

  csa_mul_seq #(.WIDTH(32), .STEPS_AT_ONCE(1), .CARRY_CHAIN(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rs1(a_rs1), .rs2(a_rs2), .rs1_signed(a_rs1_signed), .rs2_signed(a_rs2_signed),
    .abort(a_abort), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .product(a_product)
  );

  csa_mul_seq #(.WIDTH(8), .STEPS_AT_ONCE(2), .CARRY_CHAIN(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rs1(b_rs1), .rs2(b_rs2), .rs1_signed(b_rs1_signed), .rs2_signed(b_rs2_signed),
    .abort(b_abort), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .product(b_product)
  );

  // Offer one operand pair, count edges from accept to out_valid, then consume.
  task automatic run_a(input logic [31:0] x, input logic [31:0] y,
                       input logic sx, input logic sy,
                       output logic [63:0] p, output int lat);
    a_rs1 = x; a_rs2 = y; a_rs1_signed = sx; a_rs2_signed = sy; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_abort = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    p = a_product;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [7:0] x, input logic [7:0] y,
                       input logic sx, input logic sy,
                       output logic [15:0] p, output int lat);
    b_rs1 = x; b_rs2 = y; b_rs1_signed = sx; b_rs2_signed = sy; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_abort = 1'b0;
    lat = 0;
    while (b_out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    p = b_product;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_in_ready: got %b expected 1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
    if (a_product !== 64'h0) begin errors++; $display("[TB] FAIL reset_a_product: got %h expected 0", a_product); end
    if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_in_ready: got %b expected 1", b_in_ready); end
    if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
    if (b_product !== 16'h0) begin errors++; $display("[TB] FAIL reset_b_product: got %h expected 0", b_product); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [63:0] p;
    int lat;
    run_a(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    checks += 2;
    if (lat != 33) begin errors++; $display("[TB] FAIL u3x5_latency: got %0d expected 33", lat); end
    if (p !== 64'h0000_0000_0000_000F) begin errors++; $display("[TB] FAIL u3x5_product: got %h expected %h", p, 64'hF); end
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, p, lat);
    checks += 2;
    if (lat != 33) begin errors++; $display("[TB] FAIL umax_latency: got %0d expected 33", lat); end
    if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("[TB] FAIL umax_product: got %h expected %h", p, 64'hFFFF_FFFE_0000_0001); end
  endtask

  task automatic test_signed;
    logic [63:0] p;
    int lat;
    run_a(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, p, lat);
    checks += 2;
    if (lat != 65) begin errors++; $display("[TB] FAIL sneg1x2_latency: got %0d expected 65", lat); end
    if (p !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL sneg1x2_product: got %h expected %h", p, 64'hFFFF_FFFF_FFFF_FFFE); end
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, p, lat);
    checks += 2;
    if (lat != 65) begin errors++; $display("[TB] FAIL mixed_latency: got %0d expected 65", lat); end
    if (p !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("[TB] FAIL mixed_product: got %h expected %h", p, 64'hFFFF_FFFF_0000_0001); end
    run_a(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, p, lat);
    checks += 1;
    if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("[TB] FAIL smin_sq_product: got %h expected %h", p, 64'h4000_0000_0000_0000); end
    run_a(32'd5, 32'hFFFF_FFFD, 1'b0, 1'b1, p, lat);
    checks += 1;
    if (p !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("[TB] FAIL u5xsneg3_product: got %h expected %h", p, 64'hFFFF_FFFF_FFFF_FFF1); end
  endtask

  task automatic test_backpressure;
    int lat;
    a_rs1 = 32'd7; a_rs2 = 32'd9; a_rs1_signed = 1'b0; a_rs2_signed = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    checks += 1;
    if (lat != 33) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 33", lat); end
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_rs1 = 32'd1; a_rs2 = 32'd1;
      @(posedge clk); #1;
      checks += 3;
      if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid[%0d]: got %b expected 1", i, a_out_valid); end
      if (a_product !== 64'd63) begin errors++; $display("[TB] FAIL bp_product[%0d]: got %h expected %h", i, a_product, 64'd63); end
      if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, a_in_ready); end
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    checks += 2;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_out_valid: got %b expected 0", a_out_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks += 1;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_queue: got in_ready %b expected 1", a_in_ready); end
    last_p32 = 64'd63;
  endtask

  task automatic test_abort;
    logic [63:0] p;
    int lat;
    int stray;
    a_rs1 = 32'd3; a_rs2 = 32'd5; a_rs1_signed = 1'b0; a_rs2_signed = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    checks += 3;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_run_in_ready: got %b expected 1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_run_out_valid: got %b expected 0", a_out_valid); end
    if (a_product !== last_p32) begin errors++; $display("[TB] FAIL abort_run_product: got %h expected %h", a_product, last_p32); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (a_out_valid === 1'b1) stray++;
    end
    checks += 1;
    if (stray != 0) begin errors++; $display("[TB] FAIL abort_no_pulse: got %0d valid cycles expected 0", stray); end

    // Abort held across the accept edge must not stop acceptance from IDLE.
    a_abort = 1'b1;
    run_a(32'd7, 32'd6, 1'b0, 1'b0, p, lat);
    checks += 2;
    if (lat != 33) begin errors++; $display("[TB] FAIL after_abort_latency: got %0d expected 33", lat); end
    if (p !== 64'd42) begin errors++; $display("[TB] FAIL after_abort_product: got %h expected %h", p, 64'd42); end
    last_p32 = 64'd42;

    a_rs1 = 32'd11; a_rs2 = 32'd13; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_resolve_in_ready: got %b expected 1", a_in_ready); end
    if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_resolve_out_valid: got %b expected 0", a_out_valid); end
    if (a_product !== last_p32) begin errors++; $display("[TB] FAIL abort_resolve_product: got %h expected %h", a_product, last_p32); end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] p;
    logic [15:0] q;
    int lat;
    a_rs1 = 32'd3; a_rs2 = 32'd5; a_in_valid = 1'b1;
    b_rs1 = 8'h12; b_rs2 = 8'h34; b_rs1_signed = 1'b0; b_rs2_signed = 1'b0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks += 4;
    if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_a_in_ready: got %b expected 1", a_in_ready); end
    if (a_product !== 64'h0) begin errors++; $display("[TB] FAIL midreset_a_product: got %h expected 0", a_product); end
    if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_b_in_ready: got %b expected 1", b_in_ready); end
    if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_b_out_valid: got %b expected 0", b_out_valid); end
    #2;
    reset = 1'b0;
    run_b(8'hFF, 8'hFF, 1'b0, 1'b0, q, lat);
    checks += 2;
    if (lat != 5) begin errors++; $display("[TB] FAIL w8_umax_latency: got %0d expected 5", lat); end
    if (q !== 16'hFE01) begin errors++; $display("[TB] FAIL w8_umax_product: got %h expected FE01", q); end
    run_b(8'h80, 8'h7F, 1'b1, 1'b1, q, lat);
    checks += 2;
    if (lat != 9) begin errors++; $display("[TB] FAIL w8_signed_latency: got %0d expected 9", lat); end
    if (q !== 16'hC080) begin errors++; $display("[TB] FAIL w8_signed_product: got %h expected C080", q); end
    run_a(32'd7, 32'd6, 1'b0, 1'b0, p, lat);
    checks += 1;
    if (p !== 64'd42) begin errors++; $display("[TB] FAIL after_reset_a_product: got %h expected %h", p, 64'd42); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_rs1 = '0; a_rs2 = '0; a_rs1_signed = 1'b0; a_rs2_signed = 1'b0;
    a_abort = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_rs1 = '0; b_rs2 = '0; b_rs1_signed = 1'b0; b_rs2_signed = 1'b0;
    b_abort = 1'b0; b_out_ready = 1'b0;
    last_p32 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
